control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 53 +++++
 rtl/control_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: sequencer states, opcodes, ALU codes
// and the bundle of datapath control signals.
package control_unit_pkg;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'd3;
    localparam logic [4:0] ALU_SUB = 5'd4;

    typedef struct packed {
        logic       pc_out;
        logic       mdr_out;
        logic       zlow_out;
        logic       ba_out;
        logic       c_out;
        logic       r_out;
        logic       mar_enable;
        logic       mdr_enable;
        logic       mdr_read;
        logic       ir_enable;
        logic       pc_enable;
        logic       y_enable;
        logic       zlow_in;
        logic       r_in;
        logic       ram_write;
        logic       inc_pc;
        logic       gra;
        logic       grb;
        logic       grc;
        logic [4:0] alu_op;
        logic       run;
    } ctrl_t;

    function automatic logic is_alu(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
    endfunction

    function automatic logic is_mem(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/control_unit.sv
// Moore sequencer for the single-bus datapath: three fetch steps, up to five
// execute steps, halt on the halt opcode or on Stop at an instruction boundary.
module control_unit
    import control_unit_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        MDRout,
    output logic        ZLowout,
    output logic        BAout,
    output logic        Cout,
    output logic        R_out,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        MDR_read,
    output logic        IR_enable,
    output logic        PC_enable,
    output logic        Y_enable,
    output logic        ZLowIn,
    output logic        R_in,
    output logic        RAM_write,
    output logic        IncPC,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic [4:0]  ALU_op,
    output logic        Run
);

    state_t     state;
    state_t     next_state;
    logic [4:0] op_q;
    logic [4:0] op;
    logic       last_step;
    ctrl_t      ctrl;
    logic       unused_ir;

    assign unused_ir = ^IR[26:0];

    // T3 decodes the freshly loaded IR; later steps follow the opcode latched there.
    assign op = (state == S_T3) ? IR[31:27] : op_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state <= S_RESET;
            op_q  <= OP_NOP;
        end else begin
            state <= next_state;
            if (state == S_T3) op_q <= IR[31:27];
        end
    end

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        next_state = state;
        last_step  = 1'b0;
        case (state)
            S_RESET: next_state = S_T0;
            S_T0:    next_state = S_T1;
            S_T1:    next_state = S_T2;
            S_T2:    next_state = S_T3;
            S_T3: begin
                if (op == OP_HALT)                next_state = S_HALT;
                else if (is_alu(op) || is_mem(op)) next_state = S_T4;
                else                               last_step  = 1'b1;
            end
            S_T4:    next_state = S_T5;
            S_T5: begin
                if (is_mem(op)) next_state = S_T6;
                else            last_step  = 1'b1;
            end
            S_T6:    next_state = S_T7;
            S_T7:    last_step  = 1'b1;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_RESET;
        endcase
        if (last_step) next_state = Stop ? S_HALT : S_T0;
    end

    always_comb begin
        ctrl     = '0;
        ctrl.run = (state != S_RESET) && (state != S_HALT);
        case (state)
            S_T0: begin
                ctrl.pc_out = 1'b1; ctrl.mar_enable = 1'b1;
                ctrl.inc_pc = 1'b1; ctrl.zlow_in    = 1'b1;
            end
            S_T1: begin
                ctrl.zlow_out = 1'b1; ctrl.pc_enable  = 1'b1;
                ctrl.mdr_read = 1'b1; ctrl.mdr_enable = 1'b1;
            end
            S_T2: begin
                ctrl.mdr_out = 1'b1; ctrl.ir_enable = 1'b1;
            end
            S_T3: begin
                if (is_alu(op)) begin
                    ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_enable = 1'b1;
                end else if (is_mem(op)) begin
                    ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_enable = 1'b1;
                end else if (op == OP_JR) begin
                    ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_enable = 1'b1;
                end
            end
            S_T4: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    ctrl.grc     = 1'b1; ctrl.r_out = 1'b1; ctrl.zlow_in = 1'b1;
                    ctrl.alu_op  = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
                end else if (op == OP_ADDI || is_mem(op)) begin
                    ctrl.c_out  = 1'b1; ctrl.zlow_in = 1'b1;
                    ctrl.alu_op = ALU_ADD;
                end
            end
            S_T5: begin
                if (is_alu(op)) begin
                    ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                end else if (is_mem(op)) begin
                    ctrl.zlow_out = 1'b1; ctrl.mar_enable = 1'b1;
                end
            end
            S_T6: begin
                if (op == OP_LD) begin
                    ctrl.mdr_read = 1'b1; ctrl.mdr_enable = 1'b1;
                end else if (op == OP_ST) begin
                    ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_enable = 1'b1;
                end
            end
            S_T7: begin
                if (op == OP_LD) begin
                    ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                end else if (op == OP_ST) begin
                    ctrl.ram_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign PCout      = ctrl.pc_out;
    assign MDRout     = ctrl.mdr_out;
    assign ZLowout    = ctrl.zlow_out;
    assign BAout      = ctrl.ba_out;
    assign Cout       = ctrl.c_out;
    assign R_out      = ctrl.r_out;
    assign MAR_enable = ctrl.mar_enable;
    assign MDR_enable = ctrl.mdr_enable;
    assign MDR_read   = ctrl.mdr_read;
    assign IR_enable  = ctrl.ir_enable;
    assign PC_enable  = ctrl.pc_enable;
    assign Y_enable   = ctrl.y_enable;
    assign ZLowIn     = ctrl.zlow_in;
    assign R_in       = ctrl.r_in;
    assign RAM_write  = ctrl.ram_write;
    assign IncPC      = ctrl.inc_pc;
    assign Gra        = ctrl.gra;
    assign Grb        = ctrl.grb;
    assign Grc        = ctrl.grc;
    assign ALU_op     = ctrl.alu_op;
    assign Run        = ctrl.run;

endmodule
